// File: rtl/ripple_adder_8bit.sv
// Registered 8-bit ripple-carry adder built from an explicit chain of full-adder stages.
// Optional status flags (overflow/zero/negative) are compiled only with RIPPLE_ADDER_FLAGS_EN.

module ripple_adder_8bit_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic       in_valid,
  output logic [7:0] sum,
  output logic       carry_out,
  output logic       out_valid,
  output logic       overflow,
  output logic       zero,
  output logic       negative
);

  logic [7:0] s_p0;
  logic [8:0] c_p0;
  logic [7:0] sum_p1;
  logic       cout_p1;
  logic       vld_p1;

  // Stage p0: combinational ripple chain, c_p0[i] is the carry into bit i
  assign c_p0[0] = carry_in;

  for (genvar i = 0; i < 8; i++) begin : g_stage
    ripple_adder_8bit_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c_p0[i]),
      .s    (s_p0[i]),
      .cout (c_p0[i+1])
    );
  end

  // Stage p1: output registers, result held while in_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= 8'h00;
      cout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= s_p0;
        cout_p1 <= c_p0[8];
      end
    end
  end

  assign sum       = sum_p1;
  assign carry_out = cout_p1;
  assign out_valid = vld_p1;

`ifdef RIPPLE_ADDER_FLAGS_EN
  logic ovf_p1;
  logic zero_p1;
  logic neg_p1;

  // Signed overflow: carry into the sign bit disagrees with carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      neg_p1  <= 1'b0;
    end else if (in_valid) begin
      ovf_p1  <= c_p0[7] ^ c_p0[8];
      zero_p1 <= (s_p0 == 8'h00);
      neg_p1  <= s_p0[7];
    end
  end

  assign overflow = ovf_p1;
  assign zero     = zero_p1;
  assign negative = neg_p1;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_adder_8bit.sv
// Directed-vector bench for ripple_adder_8bit; flag expectations follow RIPPLE_ADDER_FLAGS_EN.

module tb_ripple_adder_8bit;

`ifdef RIPPLE_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic       in_valid;
  logic [7:0] sum;
  logic       carry_out;
  logic       out_valid;
  logic       overflow;
  logic       zero;
  logic       negative;

  int n_vec;
  int n_bad;

  ripple_adder_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .out_valid (out_valid),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_sum, input logic e_co,
                           input logic e_vld, input logic e_ovf, input logic e_z, input logic e_n);
    check({tag, ".sum"}, sum, e_sum);
    check({tag, ".cout"}, {7'd0, carry_out}, {7'd0, e_co});
    check({tag, ".vld"}, {7'd0, out_valid}, {7'd0, e_vld});
    check({tag, ".ovf"}, {7'd0, overflow}, {7'd0, e_ovf & FLAGS});
    check({tag, ".zero"}, {7'd0, zero}, {7'd0, e_z & FLAGS});
    check({tag, ".neg"}, {7'd0, negative}, {7'd0, e_n & FLAGS});
  endtask

  // Present one operation, let it be captured, then sample just after the edge.
  task automatic op(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic ci,
                    input logic [7:0] e_sum, input logic e_co, input logic e_ovf,
                    input logic e_z, input logic e_n);
    a = va; b = vb; carry_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    check_all(tag, e_sum, e_co, 1'b1, e_ovf, e_z, e_n);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; a = 8'h00; b = 8'h00; carry_in = 1'b0; in_valid = 1'b0;

    // Inputs toggle while reset is held
    for (int i = 0; i < 4; i++) begin
      a = 8'hA5 ^ 8'(i); b = 8'h5A; carry_in = i[0]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back operations
    op("add3_4",  8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    op("wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    op("sub4_2",  8'h04, 8'hFD, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    op("sub0_1",  8'h00, 8'hFE, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op("ovf55",   8'h55, 8'h55, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b1);
    op("m80_7f",  8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    op("ffff1",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    op("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    op("mix",     8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 1'b1);

    // Hold: inputs change but nothing is captured
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 8'h11 + 8'(i); b = 8'h22; carry_in = 1'b1;
      @(posedge clk); #1;
      check_all("hold", 8'h88, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    // Reset between edges clears immediately and discards the pending operation
    a = 8'h10; b = 8'h20; carry_in = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("rst_edge", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    op("first_cap", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({"vld_drop"}, {7'd0, out_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
